fp_mul_seq: RTL and testbench
=============================

FP_MUL_SEQ -- requirements
Module: fp_mul_seq

Interface
REQ-001 Parameter: NEXP, default 5, exponent width.
REQ-002 Parameter: NSIG, default 10, stored significand width; operand/result width NEXP+NSIG+1.
REQ-003 The widths and bit positions of ra, pFlags and exception SHALL come from the shared include ieee-754-flags.vh: NRAS, NTYPES, NEXCEPTIONS, roundTiesToEven, roundTowardZero, roundTowardPositive, roundTowardNegative, roundTiesToAway.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  operands and rounding mode valid.
REQ-007 in_ready  out  1  block can accept; a transfer occurs when in_valid && in_ready.
REQ-008 a, b  in  NEXP+NSIG+1  IEEE-754 multiplicand and multiplier.
REQ-009 ra  in  NRAS+1  one-hot rounding mode.
REQ-010 out_valid  out  1  p, pFlags and exception valid.
REQ-011 out_ready  in  1  consumer accepts; the result retires when out_valid && out_ready.
REQ-012 p  out  NEXP+NSIG+1  product a*b.
REQ-013 pFlags  out  NTYPES  one-hot class of p: sNaN, qNaN, infinity, zero, subnormal, normal.
REQ-014 exception  out  NEXCEPTIONS  invalid, divideByZero (always 0), overflow, underflow, inexact.

Function
REQ-015 States: IDLE, MUL, NORM, ROUND, DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 On transfer, a, b and ra SHALL be registered; the block SHALL ignore later input changes until it returns to IDLE.
REQ-017 Special operands SHALL be resolved on transfer, and the block SHALL go directly from IDLE to DONE, giving out_valid one cycle after the transfer.
REQ-018 sNaN in either operand SHALL produce a quieted NaN with invalid=1. The result SHALL be a with significand MSB set if a is NaN, otherwise b quieted. Two qNaN operands SHALL return a.
REQ-019 infinity*zero in either order SHALL produce the default qNaN (sign 0, exponent all ones, significand MSB only) with invalid=1.
REQ-020 infinity*finite-nonzero SHALL produce infinity; zero*finite SHALL produce zero. Neither case raises a flag.
REQ-021 For every non-NaN result, the sign of p SHALL be sign(a) XOR sign(b).
REQ-022 For finite nonzero operands, the block SHALL prepend a hidden bit (1 for normal, 0 for subnormal; subnormal exponent 1). The block SHALL then spend exactly NSIG+1 cycles in MUL, doing one shift-add step per cycle into a 2*(NSIG+1)-bit product register. The unbiased exponent sum SHALL be held signed with 2 guard bits.
REQ-023 NORM SHALL last 1 cycle. It SHALL left-justify the product, adjust the exponent, and form guard and sticky bits. If the exponent is below the minimum, it SHALL right-shift to the subnormal position, OR-ing shifted-out bits into sticky.
REQ-024 ROUND SHALL last 1 cycle and apply ra.
- roundTiesToEven: round to nearest, ties to even.
- roundTiesToAway: round to nearest, ties away from zero.
- roundTowardZero: truncate.
- roundTowardPositive / roundTowardNegative: increment on inexact when the sign is 0 / 1 respectively.
- A significand carry-out SHALL increment the exponent.
REQ-025 Finite latency SHALL be NSIG+4 cycles from transfer to out_valid=1 (14 for binary16).
REQ-026 On overflow, the block SHALL raise overflow and inexact.
- Result SHALL be infinity under ties modes and under directed rounding toward the result's sign.
- Otherwise the result SHALL be the largest finite value.
REQ-027 underflow SHALL be raised only when the result is tiny (after rounding) and inexact; inexact SHALL be raised whenever round or sticky is nonzero.
REQ-028 A result that rounds to zero SHALL be zero with the correct sign, with underflow and inexact raised.
REQ-029 In DONE, out_valid=1, and p, pFlags and exception SHALL hold stable while out_ready=0.
REQ-030 On retire, the block SHALL go to IDLE; in_ready SHALL rise the next cycle (no same-cycle re-accept).
REQ-031 ra not one-hot SHALL be treated as roundTiesToEven.

Reset
REQ-032 With rst=1 at a rising edge, the state SHALL go to IDLE in any state, including mid-MUL, and the in-flight operation SHALL be discarded without output.
REQ-033 Reset values SHALL be: in_ready=1, out_valid=0, p=0, pFlags=0, exception=0, internal registers 0.
REQ-034 After reset deasserts, the first transfer SHALL be possible in the first cycle.

Verification
REQ-035 a=4200, b=3C00, ra=roundTiesToEven, out_ready=1 -> p=4200, pFlags=normal, exception=0, out_valid 14 cycles after transfer.
REQ-036 Operands:
- a=3E00, b=3E00 -> p=4080, exception=0.
- a=3555, b=4200 -> p=3BFF, inexact=1.
REQ-037 a=7C0A (sNaN), b=3C00 -> p=7E0A, invalid=1, 1-cycle latency; a=7C00, b=8000 -> p=7E00, invalid=1.
REQ-038 a=7BFF, b=4000:
- ra=roundTiesToEven -> p=7C00, overflow=1, inexact=1.
- ra=roundTowardZero -> p=7BFF, overflow=1, inexact=1.
REQ-039 Operands:
- a=0400, b=3800 -> p=0200, exception=0.
- a=0001, b=3800, roundTiesToEven -> p=0000, underflow=1, inexact=1.
REQ-040 Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0. Assert rst during MUL -> next cycle in_ready=1, out_valid=0, no result emitted.

Source files
------------

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 multiplier: radix-2 shift-add significand product, then normalise and round.
// NaN/infinity/zero operands bypass the datapath and retire one cycle after the transfer.
module fp_mul_seq #(
  parameter  int NEXP        = 5,
  parameter  int NSIG        = 10,
  localparam int NRAS        = 4,
  localparam int NTYPES      = 6,
  localparam int NEXCEPTIONS = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NEXP+NSIG:0]     a,
  input  logic [NEXP+NSIG:0]     b,
  input  logic [NRAS:0]          ra,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NEXP+NSIG:0]     p,
  output logic [NTYPES-1:0]      pFlags,
  output logic [NEXCEPTIONS-1:0] exception
);

  // Bit positions shared with the ieee-754-flags definitions
  localparam int roundTiesToEven     = 0;
  localparam int roundTowardZero     = 1;
  localparam int roundTowardPositive = 2;
  localparam int roundTowardNegative = 3;
  localparam int roundTiesToAway     = 4;
  localparam int SNAN = 5, QNAN = 4, INFINITY = 3, ZERO = 2, SUBNORMAL = 1, NORMAL = 0;
  localparam int INVALID = 4, OVERFLOW = 2, UNDERFLOW = 1, INEXACT = 0;

  localparam int MSB  = NEXP + NSIG;
  localparam int W    = NSIG + 1;
  localparam int PW   = 2 * W;
  localparam int EW   = NEXP + 2;
  localparam int CW   = $clog2(W + 1);
  localparam int BIAS = (1 << (NEXP - 1)) - 1;
  localparam int EMIN = 1 - BIAS;
  localparam int EMAX = BIAS;

  typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} state_t;

  state_t                   state_q;
  logic                     in_ready_q, out_valid_q;
  logic [MSB:0]             p_q;
  logic [NTYPES-1:0]        pflags_q;
  logic [NEXCEPTIONS-1:0]   exc_q;
  logic                     sign_q;
  logic [NRAS:0]            ra_q;
  logic [PW-1:0]            mcand_q, prod_q;
  logic [W-1:0]             mplier_q;
  logic [CW-1:0]            cnt_q;
  logic signed [EW-1:0]     exp_q;
  logic                     sticky_q;

  function automatic logic [NTYPES-1:0] classify(input logic [MSB:0] v);
    logic [NEXP-1:0] e;
    logic [NSIG-1:0] f;
    e = v[MSB-1:NSIG];
    f = v[NSIG-1:0];
    classify = '0;
    if (&e) begin
      if (|f) classify[f[NSIG-1] ? QNAN : SNAN] = 1'b1;
      else    classify[INFINITY] = 1'b1;
    end else if (~|e) begin
      classify[(|f) ? SUBNORMAL : ZERO] = 1'b1;
    end else begin
      classify[NORMAL] = 1'b1;
    end
  endfunction

  // Operand decode and special-case resolution at transfer
  logic [NEXP-1:0]        a_exp, b_exp;
  logic [NSIG-1:0]        a_frac, b_frac;
  logic                   a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic                   sign_d, special_d;
  logic [MSB:0]           spec_p_d;
  logic [NEXCEPTIONS-1:0] spec_exc_d;
  logic [W-1:0]           a_sig, b_sig;
  logic signed [EW-1:0]   a_e, b_e;

  always_comb begin
    a_exp  = a[MSB-1:NSIG];
    b_exp  = b[MSB-1:NSIG];
    a_frac = a[NSIG-1:0];
    b_frac = b[NSIG-1:0];
    a_nan  = (&a_exp) & (|a_frac);
    b_nan  = (&b_exp) & (|b_frac);
    a_snan = a_nan & ~a_frac[NSIG-1];
    b_snan = b_nan & ~b_frac[NSIG-1];
    a_inf  = (&a_exp) & ~(|a_frac);
    b_inf  = (&b_exp) & ~(|b_frac);
    a_zero = ~(|a_exp) & ~(|a_frac);
    b_zero = ~(|b_exp) & ~(|b_frac);
    a_sig  = {|a_exp, a_frac};
    b_sig  = {|b_exp, b_frac};
    a_e    = (|a_exp) ? $signed({2'b00, a_exp}) - EW'(BIAS) : EW'(EMIN);
    b_e    = (|b_exp) ? $signed({2'b00, b_exp}) - EW'(BIAS) : EW'(EMIN);
    sign_d = a[MSB] ^ b[MSB];

    special_d  = 1'b1;
    spec_p_d   = '0;
    spec_exc_d = '0;
    if (a_snan | b_snan) begin
      spec_p_d           = a_nan ? a : b;
      spec_p_d[NSIG-1]   = 1'b1;
      spec_exc_d[INVALID] = 1'b1;
    end else if (a_nan | b_nan) begin
      spec_p_d = a_nan ? a : b;
    end else if ((a_inf & b_zero) | (a_zero & b_inf)) begin
      spec_p_d            = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
      spec_exc_d[INVALID] = 1'b1;
    end else if (a_inf | b_inf) begin
      spec_p_d = {sign_d, {NEXP{1'b1}}, {NSIG{1'b0}}};
    end else if (a_zero | b_zero) begin
      spec_p_d = {sign_d, {(NEXP+NSIG){1'b0}}};
    end else begin
      special_d = 1'b0;
    end
  end

  // Normalise: left-justify the product, then denormalise below EMIN with sticky collection
  logic [PW-1:0]        norm_prod_d, n;
  logic signed [EW-1:0] norm_exp_d;
  logic                 norm_sticky_d;
  int                   lz, e_n, sh;

  always_comb begin
    lz = 0;
    for (int unsigned i = 0; i < PW; i++) begin
      if (prod_q[i]) lz = PW - 1 - int'(i);
    end
    n             = prod_q << lz;
    e_n           = int'(exp_q) + 1 - lz;
    sh            = 0;
    norm_sticky_d = 1'b0;
    if (e_n < EMIN) begin
      sh = EMIN - e_n;
      if (sh > PW) sh = PW;
      norm_sticky_d = |(n & ~({PW{1'b1}} << sh));
      n   = n >> sh;
      e_n = EMIN;
    end
    norm_prod_d = n;
    norm_exp_d  = EW'(e_n);
  end

  // Round: top W bits are the significand, next bit is guard, the rest folds into sticky
  logic [NRAS:0]          rm;
  logic [W-1:0]           sig, sig_r;
  logic [W:0]             sum;
  logic                   guard, stk, inexact, inc, to_inf;
  int                     e_r;
  logic [MSB:0]           round_p_d;
  logic [NEXCEPTIONS-1:0] round_exc_d;

  always_comb begin
    rm = '0;
    rm[roundTiesToEven] = 1'b1;
    if ($onehot(ra_q)) rm = ra_q;
    sig     = prod_q[PW-1 -: W];
    guard   = prod_q[NSIG];
    stk     = sticky_q | (|prod_q[NSIG-1:0]);
    inexact = guard | stk;
    if (rm[roundTowardZero])           inc = 1'b0;
    else if (rm[roundTowardPositive])  inc = inexact & ~sign_q;
    else if (rm[roundTowardNegative])  inc = inexact & sign_q;
    else if (rm[roundTiesToAway])      inc = guard;
    else                               inc = guard & (stk | sig[0]);
    sum    = {1'b0, sig} + {{W{1'b0}}, inc};
    sig_r  = sum[W] ? sum[W:1] : sum[W-1:0];
    e_r    = int'(exp_q) + int'(sum[W]);
    to_inf = rm[roundTiesToEven] | rm[roundTiesToAway] |
             (rm[roundTowardPositive] & ~sign_q) | (rm[roundTowardNegative] & sign_q);

    round_exc_d          = '0;
    round_exc_d[INEXACT] = inexact;
    if (e_r > EMAX) begin
      round_exc_d[OVERFLOW] = 1'b1;
      round_exc_d[INEXACT]  = 1'b1;
      round_p_d = to_inf ? {sign_q, {NEXP{1'b1}}, {NSIG{1'b0}}}
                         : {sign_q, {(NEXP-1){1'b1}}, 1'b0, {NSIG{1'b1}}};
    end else begin
      // a clear hidden bit means subnormal or zero: biased exponent field is 0
      round_p_d = {sign_q, (sig_r[NSIG] ? NEXP'(e_r + BIAS) : {NEXP{1'b0}}), sig_r[NSIG-1:0]};
      round_exc_d[UNDERFLOW] = ~sig_r[NSIG] & inexact;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      p_q         <= '0;
      pflags_q    <= '0;
      exc_q       <= '0;
      sign_q      <= 1'b0;
      ra_q        <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      exp_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            ra_q       <= ra;
            sign_q     <= sign_d;
            if (special_d) begin
              p_q         <= spec_p_d;
              pflags_q    <= classify(spec_p_d);
              exc_q       <= spec_exc_d;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              mcand_q  <= {{W{1'b0}}, a_sig};
              mplier_q <= b_sig;
              prod_q   <= '0;
              cnt_q    <= '0;
              exp_q    <= a_e + b_e;
              sticky_q <= 1'b0;
              state_q  <= MUL;
            end
          end
        end
        MUL: begin
          if (mplier_q[0]) prod_q <= prod_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(W - 1)) state_q <= NORM;
        end
        NORM: begin
          prod_q   <= norm_prod_d;
          exp_q    <= norm_exp_d;
          sticky_q <= norm_sticky_d;
          state_q  <= ROUND;
        end
        ROUND: begin
          p_q         <= round_p_d;
          pflags_q    <= classify(round_p_d);
          exc_q       <= round_exc_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign p         = p_q;
  assign pFlags    = pflags_q;
  assign exception = exc_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Bench for fp_mul_seq (binary16): directed vectors plus random operands checked
// against an exact integer-quantum rounding model.
module tb_fp_mul_seq;

  localparam int NEXP = 5;
  localparam int NSIG = 10;
  localparam int RNE = 0, RTZ = 1, RTP = 2, RTN = 3, RNA = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, p;
  logic [4:0]  ra;
  logic [5:0]  pFlags;
  logic [4:0]  exception;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fp_mul_seq #(.NEXP(NEXP), .NSIG(NSIG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ra(ra), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .pFlags(pFlags), .exception(exception)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact product m*2^e, rounded to a multiple of the result quantum 2^q.
  function automatic void model(input logic [15:0] x, input logic [15:0] y, input logic [4:0] mode,
                                output logic [15:0] r, output logic [5:0] fl,
                                output logic [4:0] ex, output bit spec);
    int     xe, ye, xu, yu, md, lead, q, sh, e;
    bit     xnan, ynan, xsnan, ysnan, xinf, yinf, xzero, yzero, s, inexact, up, to_inf;
    longint mx, my, m, rr, rem, half;
    xe = int'(x[14:10]);
    ye = int'(y[14:10]);
    xnan = (xe == 31) && (x[9:0] != 0);
    ynan = (ye == 31) && (y[9:0] != 0);
    xsnan = xnan && !x[9];
    ysnan = ynan && !y[9];
    xinf = (xe == 31) && (x[9:0] == 0);
    yinf = (ye == 31) && (y[9:0] == 0);
    xzero = (x[14:0] == 0);
    yzero = (y[14:0] == 0);
    s = x[15] ^ y[15];
    md = RNE;
    if ($countones(mode) == 1)
      for (int i = 0; i < 5; i++) if (mode[i]) md = i;
    r = '0; fl = '0; ex = '0; spec = 1'b1;
    if (xsnan || ysnan) begin
      r = xnan ? (x | 16'h0200) : (y | 16'h0200); fl[4] = 1'b1; ex[4] = 1'b1;
    end else if (xnan || ynan) begin
      r = xnan ? x : y; fl[4] = 1'b1;
    end else if ((xinf && yzero) || (xzero && yinf)) begin
      r = 16'h7E00; fl[4] = 1'b1; ex[4] = 1'b1;
    end else if (xinf || yinf) begin
      r = {s, 15'h7C00}; fl[3] = 1'b1;
    end else if (xzero || yzero) begin
      r = {s, 15'h0000}; fl[2] = 1'b1;
    end else begin
      spec = 1'b0;
      mx = (xe == 0) ? longint'(x[9:0]) : 1024 + longint'(x[9:0]);
      my = (ye == 0) ? longint'(y[9:0]) : 1024 + longint'(y[9:0]);
      xu = (xe == 0) ? -14 : xe - 15;
      yu = (ye == 0) ? -14 : ye - 15;
      m = mx * my;
      e = xu + yu - 20;
      lead = 0;
      for (int i = 0; i < 64; i++) if (m[i]) lead = i;
      q = lead + e - 10;
      if (q < -24) q = -24;
      sh = q - e;
      rem = 0; half = 0;
      if (sh <= 0) rr = m <<< (-sh);
      else begin
        rr = m >>> sh;
        rem = m - (rr <<< sh);
        half = longint'(1) <<< (sh - 1);
      end
      inexact = (rem != 0);
      case (md)
        RTZ:     up = 1'b0;
        RTP:     up = inexact && !s;
        RTN:     up = inexact && s;
        RNA:     up = inexact && (rem >= half);
        default: up = inexact && ((rem > half) || (rem == half && rr[0]));
      endcase
      rr = rr + (up ? 1 : 0);
      if (rr == 2048) begin rr = 1024; q++; end
      if (q > 5) begin
        to_inf = (md == RNE) || (md == RNA) || (md == RTP && !s) || (md == RTN && s);
        r = to_inf ? {s, 15'h7C00} : {s, 15'h7BFF};
        fl[to_inf ? 3 : 0] = 1'b1;
        ex[2] = 1'b1; ex[0] = 1'b1;
      end else if (rr < 1024) begin
        r = {s, 5'd0, rr[9:0]};
        fl[(rr == 0) ? 2 : 1] = 1'b1;
        ex[1] = inexact; ex[0] = inexact;
      end else begin
        r = {s, 5'(q + 25), 10'(rr - 1024)};
        fl[0] = 1'b1;
        ex[0] = inexact;
      end
    end
  endfunction

  // One full transaction; hold>0 keeps out_ready low for that many cycles in DONE.
  task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic [4:0] mode,
                       input int hold, output logic [15:0] cp, output logic [5:0] cf,
                       output logic [4:0] ce);
    logic [15:0] ep;
    logic [5:0]  ef;
    logic [4:0]  ee;
    bit          spec;
    int          lat;
    model(x, y, mode, ep, ef, ee, spec);
    a = x; b = y; ra = mode; in_valid = 1'b1; out_ready = (hold == 0);
    check("in_ready_before_transfer", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); ra = 5'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    cp = p; cf = pFlags; ce = exception;
    check("latency", lat, spec ? 1 : NSIG + 4);
    check($sformatf("p %h*%h ra=%b", x, y, mode), p, ep);
    check($sformatf("pFlags %h*%h", x, y), pFlags, ef);
    check($sformatf("exception %h*%h ra=%b", x, y, mode), exception, ee);
    if (lat < 64) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("hold_stable", {out_valid, in_ready, p, pFlags, exception}, {1'b1, 1'b0, cp, cf, ce});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("retire_out_valid", out_valid, 0);
      check("retire_in_ready", in_ready, 1);
    end
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 7))
      0: case ($urandom_range(0, 5))
           0: v = 16'h0000;
           1: v = 16'h8000;
           2: v = 16'h7C00;
           3: v = 16'hFC00;
           4: v = 16'h7E00 | 16'($urandom_range(0, 255));
           default: v = 16'h7C01 | 16'($urandom_range(0, 255));
         endcase
      1: v[14:10] = 5'($urandom_range(0, 3));
      2: v[14:10] = 5'($urandom_range(27, 30));
      3: v[14:10] = 5'($urandom_range(8, 22));
      default: ;
    endcase
    return v;
  endfunction

  logic [15:0] cp;
  logic [5:0]  cf;
  logic [4:0]  ce;
  logic [4:0]  mode;
  int          seen;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ra = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_p", p, 0);
    check("reset_pFlags", pFlags, 0);
    check("reset_exception", exception, 0);
    rst = 1'b0;

    do_op(16'h4200, 16'h3C00, 5'b00001, 0, cp, cf, ce);
    check("dir_4200x3C00_p", cp, 16'h4200);
    check("dir_4200x3C00_flags", cf, 6'b000001);
    check("dir_4200x3C00_exc", ce, 5'b00000);
    do_op(16'h3E00, 16'h3E00, 5'b00001, 0, cp, cf, ce);
    check("dir_3E00x3E00_p", {ce, cp}, {5'b00000, 16'h4080});
    do_op(16'h3555, 16'h4200, 5'b00010, 0, cp, cf, ce);
    check("dir_3555x4200_rtz", {ce, cp}, {5'b00001, 16'h3BFF});
    do_op(16'h3555, 16'h4200, 5'b00011, 0, cp, cf, ce);
    check("dir_ra_not_onehot_rne", {ce, cp}, {5'b00001, 16'h3C00});
    do_op(16'h7C0A, 16'h3C00, 5'b00001, 0, cp, cf, ce);
    check("dir_snan", {ce, cp}, {5'b10000, 16'h7E0A});
    do_op(16'h7C00, 16'h8000, 5'b00001, 0, cp, cf, ce);
    check("dir_inf_x_zero", {ce, cp}, {5'b10000, 16'h7E00});
    do_op(16'h7BFF, 16'h4000, 5'b00001, 0, cp, cf, ce);
    check("dir_ovf_rne", {ce, cp}, {5'b00101, 16'h7C00});
    do_op(16'h7BFF, 16'h4000, 5'b00010, 0, cp, cf, ce);
    check("dir_ovf_rtz", {ce, cp}, {5'b00101, 16'h7BFF});
    do_op(16'h0400, 16'h3800, 5'b00001, 0, cp, cf, ce);
    check("dir_min_normal_half", {ce, cp}, {5'b00000, 16'h0200});
    do_op(16'h0001, 16'h3800, 5'b00001, 0, cp, cf, ce);
    check("dir_underflow_to_zero", {ce, cp}, {5'b00011, 16'h0000});
    do_op(16'h3E00, 16'hC200, 5'b00001, 5, cp, cf, ce);

    a = 16'h3C00; b = 16'h4000; ra = 5'b00001; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_mul_reset_in_ready", in_ready, 1);
    check("mid_mul_reset_out_valid", out_valid, 0);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("no_result_after_reset", seen, 0);

    for (int n = 0; n < 250; n++) begin
      mode = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'(1 << $urandom_range(0, 4));
      do_op(pick(), pick(), mode, ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0, cp, cf, ce);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
